line_memory_responder: RTL and testbench

Next-level memory responder that services the cache's line-granular refill reads and dirty-line writebacks. It sits on the cache's next-level master port and models the downstream memory as a line-wide array with a fixed, parameterised access latency. Each accepted request gets exactly one `valid` pulse back; requests are strictly serialised, one in flight at a time.

---
 rtl/line_memory_responder.sv | 146 ++++++++++++++
 tb/tb_line_memory_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/line_memory_responder.sv
// line_memory_responder: line-wide backing memory behind the cache's
// next-level port, answering one read or writeback after LATENCY cycles.
// Ports: clock, reset (async, active-low), request/write/addr/wdata in,
// rdata/valid/busy out; err out only when MEMRESP_ERR_EN is defined.
module line_memory_responder #(
    parameter int ADDRBITS  = 32,
    parameter int WORDBITS  = 32,
    parameter int LINEITEMS = 4,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          request,
    input  logic                          write,
    input  logic [ADDRBITS-1:0]           addr,
    input  logic [LINEITEMS*WORDBITS-1:0] wdata,
    output logic [LINEITEMS*WORDBITS-1:0] rdata,
    output logic                          valid,
`ifdef MEMRESP_ERR_EN
    output logic                          err,
`endif
    output logic                          busy
);

    localparam int LINEBITS = LINEITEMS * WORDBITS;
    localparam int OFFBITS  = $clog2(LINEBITS / 8);
    localparam int SLOTBITS = $clog2(DEPTH);
    localparam int CNTBITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } state_t;

    state_t                state;
    logic [CNTBITS-1:0]    count;
    logic                  lat_write;
    logic                  lat_oor;
    logic [SLOTBITS-1:0]   lat_slot;
    logic [LINEBITS-1:0]   lat_wdata;

    logic [LINEBITS-1:0]   mem [DEPTH];

    logic [SLOTBITS-1:0]   req_slot;
    logic                  req_oor;
    logic                  unused_bits;

    assign req_slot = addr[OFFBITS +: SLOTBITS];

`ifdef MEMRESP_ERR_EN
    assign req_oor     = |addr[ADDRBITS-1:OFFBITS+SLOTBITS];
    assign unused_bits = ^addr[OFFBITS-1:0];
`else
    // Upper index bits are dropped so addresses alias modulo DEPTH.
    assign req_oor     = 1'b0;
    assign unused_bits = ^{addr[ADDRBITS-1:OFFBITS+SLOTBITS],
                           addr[OFFBITS-1:0]};
`endif

    // Commit happens on the edge that enters RESPOND. With LATENCY=1
    // that is the accepting edge, so the live inputs are used instead
    // of the latched copies.
    logic                  commit_direct;
    logic                  commit_wait;
    logic                  commit;
    logic                  c_write;
    logic                  c_oor;
    logic [SLOTBITS-1:0]   c_slot;
    logic [LINEBITS-1:0]   c_wdata;

    always_comb begin
        commit_direct = (LATENCY == 1) && (state == IDLE) && request;
        commit_wait   = (state == WAIT) && (count == CNTBITS'(1));
        // Gating with reset keeps an aborted request from writing.
        commit        = reset && (commit_direct || commit_wait);
        c_write       = commit_direct ? write    : lat_write;
        c_oor         = commit_direct ? req_oor  : lat_oor;
        c_slot        = commit_direct ? req_slot : lat_slot;
        c_wdata       = commit_direct ? wdata    : lat_wdata;
    end

    // Storage is deliberately outside reset.
    always_ff @(posedge clock) begin
        if (commit && c_write && !c_oor) begin
            mem[c_slot] <= c_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            rdata     <= '0;
            lat_write <= 1'b0;
            lat_oor   <= 1'b0;
            lat_slot  <= '0;
            lat_wdata <= '0;
`ifdef MEMRESP_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            valid <= commit;
`ifdef MEMRESP_ERR_EN
            err   <= commit && c_oor;
`endif
            if (commit && !c_write) begin
                rdata <= c_oor ? {LINEBITS{1'b1}} : mem[c_slot];
            end
            unique case (state)
                IDLE: begin
                    if (request) begin
                        lat_write <= write;
                        lat_oor   <= req_oor;
                        lat_slot  <= req_slot;
                        lat_wdata <= wdata;
                        busy      <= 1'b1;
                        if (LATENCY == 1) begin
                            state <= RESPOND;
                        end else begin
                            state <= WAIT;
                            count <= CNTBITS'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    count <= count - CNTBITS'(1);
                    if (count == CNTBITS'(1)) begin
                        state <= RESPOND;
                    end
                end
                RESPOND: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_memory_responder.sv
// Directed bench for line_memory_responder: LATENCY=4 instance for the
// main sequence, LATENCY=1 instance for back-to-back requests.
module tb_line_memory_responder;

    logic         clock = 1'b0;
    logic         reset;

    logic         req_a, wr_a, valid_a, busy_a;
    logic [31:0]  addr_a;
    logic [127:0] wd_a, rd_a;

    logic         req_b, wr_b, valid_b, busy_b;
    logic [31:0]  addr_b;
    logic [127:0] wd_b, rd_b;

`ifdef MEMRESP_ERR_EN
    logic         err_a, err_b;
`endif

    int tests = 0;
    int fails = 0;

    localparam logic [127:0] D1 =
        128'hDEADBEEF_0BEEFA55_12345678_CAFEF00D;
    localparam logic [127:0] D2 =
        128'h55555555_AAAAAAAA_01010101_F0F0F0F0;
    localparam logic [127:0] D3 =
        128'h0000_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [127:0] E0 = 128'hE0E0_0000_0000_0000_0000_0000_0000_00E0;
    localparam logic [127:0] E1 = 128'hE1E1_0000_0000_0000_0000_0000_0000_00E1;

    always #5 clock = ~clock;

    line_memory_responder #(.LATENCY(4)) dut_a (
        .clock (clock),
        .reset (reset),
        .request (req_a),
        .write (wr_a),
        .addr  (addr_a),
        .wdata (wd_a),
        .rdata (rd_a),
        .valid (valid_a),
`ifdef MEMRESP_ERR_EN
        .err   (err_a),
`endif
        .busy  (busy_a)
    );

    line_memory_responder #(.LATENCY(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .request (req_b),
        .write (wr_b),
        .addr  (addr_b),
        .wdata (wd_b),
        .rdata (rd_b),
        .valid (valid_b),
`ifdef MEMRESP_ERR_EN
        .err   (err_b),
`endif
        .busy  (busy_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; issues one request to dut_a and
    // checks the full 4-cycle response window.
    task automatic seq_a(input logic w, input logic [31:0] a,
                         input logic [127:0] d, input logic [127:0] exp_rd,
                         input logic exp_err, input string tag);
        req_a = 1'b1; wr_a = w; addr_a = a; wd_a = d;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if (i == 1) req_a = 1'b0;
            chk({tag, "_valid"}, valid_a, (i == 4));
            chk({tag, "_busy"}, busy_a, 1'b1);
        end
        if (!w) chk({tag, "_rdata"}, rd_a, exp_rd);
`ifdef MEMRESP_ERR_EN
        chk({tag, "_err"}, err_a, exp_err);
`else
        if (exp_err) chk({tag, "_err_unexpected"}, 1'b0, 1'b1);
`endif
        @(negedge clock);
        chk({tag, "_valid_end"}, valid_a, 1'b0);
        chk({tag, "_busy_end"}, busy_a, 1'b0);
        if (!w) chk({tag, "_rdata_hold"}, rd_a, exp_rd);
    endtask

    task automatic seq_b(input logic w, input logic [31:0] a,
                         input logic [127:0] d, input string tag);
        req_b = 1'b1; wr_b = w; addr_b = a; wd_b = d;
        @(negedge clock);
        req_b = 1'b0;
        chk({tag, "_valid"}, valid_b, 1'b1);
        chk({tag, "_busy"}, busy_b, 1'b1);
        @(negedge clock);
        chk({tag, "_valid_end"}, valid_b, 1'b0);
        chk({tag, "_busy_end"}, busy_b, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        req_a = 1'b0; wr_a = 1'b0; addr_a = '0; wd_a = '0;
        req_b = 1'b0; wr_b = 1'b0; addr_b = '0; wd_b = '0;
        repeat (3) @(negedge clock);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_rdata", rd_a, '0);
        reset = 1'b1;
        @(negedge clock);

        seq_a(1'b1, 32'h40, D1, '0, 1'b0, "wr40");
        seq_a(1'b0, 32'h40, '0, D1, 1'b0, "rd40");
        seq_a(1'b0, 32'h4C, '0, D1, 1'b0, "rd4c");
        seq_a(1'b1, 32'h80, D2, '0, 1'b0, "wr80");

        // Read 0x40, then keep requesting 0x80 while busy.
        req_a = 1'b1; wr_a = 1'b0; addr_a = 32'h40;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if (i == 1) addr_a = 32'h80;
            if (i == 4) req_a = 1'b0;
            chk("busyreq_valid", valid_a, (i == 4));
            chk("busyreq_busy", busy_a, 1'b1);
        end
        chk("busyreq_rdata", rd_a, D1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("busyreq_novalid", valid_a, 1'b0);
            chk("busyreq_idle", busy_a, 1'b0);
            chk("busyreq_hold", rd_a, D1);
        end
        seq_a(1'b0, 32'h80, '0, D2, 1'b0, "rd80");

        // Abort a write two cycles after acceptance.
        req_a = 1'b1; wr_a = 1'b1; addr_a = 32'h40; wd_a = 128'h1;
        @(negedge clock);
        req_a = 1'b0;
        chk("abort_busy", busy_a, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_rst_valid", valid_a, 1'b0);
        chk("abort_rst_busy", busy_a, 1'b0);
        chk("abort_rst_rdata", rd_a, '0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("abort_novalid", valid_a, 1'b0);
        end
        seq_a(1'b0, 32'h40, '0, D1, 1'b0, "abort_rd40");

        // Out-of-range index 256.
        seq_a(1'b1, 32'h0, D3, '0, 1'b0, "wr0");
`ifdef MEMRESP_ERR_EN
        seq_a(1'b0, 32'h1000, '0, {128{1'b1}}, 1'b1, "oor");
`else
        seq_a(1'b0, 32'h1000, '0, D3, 1'b0, "oor");
`endif

        // LATENCY=1 instance.
        seq_b(1'b1, 32'h0, E0, "b_wr0");
        seq_b(1'b1, 32'h10, E1, "b_wr10");
        req_b = 1'b1; wr_b = 1'b0; addr_b = 32'h0;
        @(negedge clock);
        chk("b2b_v1", valid_b, 1'b1);
        chk("b2b_busy1", busy_b, 1'b1);
        chk("b2b_rd1", rd_b, E0);
        addr_b = 32'h10;
        @(negedge clock);
        chk("b2b_gap_valid", valid_b, 1'b0);
        chk("b2b_gap_busy", busy_b, 1'b0);
        @(negedge clock);
        req_b = 1'b0;
        chk("b2b_v2", valid_b, 1'b1);
        chk("b2b_rd2", rd_b, E1);
        @(negedge clock);
        chk("b2b_end_valid", valid_b, 1'b0);
        chk("b2b_end_busy", busy_b, 1'b0);
        chk("b2b_hold", rd_b, E1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
